// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the digit-serial BCD adder.
//   DIGIT_W     - bits per packed BCD digit
//   DIGIT_MAX   - largest legal BCD digit value
//   bcd_digit_t - one packed BCD digit
//   state_t     - control FSM states of bcd_serial_adder
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// bcd_serial_adder_if: operand/result handshake bundle for bcd_serial_adder.
// Build option: BCD_SUB_EN adds the 'sub' (A-B select) signal.
//   in_valid/in_ready   - operand handshake
//   a, b                - packed BCD operands, digit 0 in bits [3:0]
//   cin                 - carry-in (add) / borrow-in (sub)
//   sub                 - 1 selects A-B (BCD_SUB_EN only)
//   out_valid/out_ready - result handshake
//   sum, cout, invalid  - packed BCD result, carry/borrow out, bad-digit flag
// master drives operands and out_ready; slave is the adder.
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
`ifdef BCD_SUB_EN
  logic                  sub;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  invalid;

  modport master (
`ifdef BCD_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, invalid
  );

  modport slave (
`ifdef BCD_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, invalid
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: combinational single-digit BCD add/subtract slice.
//   a, b  - BCD digits
//   cin   - incoming carry
//   sub   - 1: add the nines' complement of b
//   digit - BCD result digit
//   cout  - outgoing decimal carry
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  logic       sub,
  output bcd_digit_t digit,
  output logic       cout
);

  bcd_digit_t       b_eff;
  logic [DIGIT_W:0] t;
  logic [DIGIT_W:0] t_adj;

  always_comb begin
    b_eff = sub ? bcd_digit_t'(DIGIT_MAX - b) : b;
    t     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    t_adj = t + 5'd6;
    if (t > 5'd9) begin
      digit = t_adj[DIGIT_W-1:0];
      cout  = 1'b1;
    end else begin
      digit = t[DIGIT_W-1:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial DIGITS-wide BCD adder, one digit per clock,
// least-significant digit first, through one shared bcd_digit_adder slice.
// Build option: BCD_SUB_EN enables A-B mode (nines' complement, borrow cin/cout).
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - bcd_serial_adder_if slave: operand and result handshakes
// Latency from operand acceptance to out_valid is DIGITS cycles.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);

  localparam int unsigned W    = DIGIT_W * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DIGITS - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic            inv_q, inv_d;
  logic            cout_q, cout_d;

  logic            in_sub;
  logic            any_bad;
  bcd_digit_t      slice_digit;
  logic            slice_cout;

`ifdef BCD_SUB_EN
  assign in_sub = bus.sub;
`else
  assign in_sub = 1'b0;
`endif

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.a[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) any_bad = 1'b1;
      if (bus.b[DIGIT_W*i +: DIGIT_W] > DIGIT_MAX) any_bad = 1'b1;
    end
  end

  bcd_digit_adder u_slice (
    .a     (a_q[DIGIT_W-1:0]),
    .b     (b_q[DIGIT_W-1:0]),
    .cin   (carry_q),
    .sub   (sub_q),
    .digit (slice_digit),
    .cout  (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    inv_d   = inv_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = in_sub;
          // Subtraction adds the nines' complement plus one, so a borrow-in
          // becomes a missing +1.
          carry_d = bus.cin ^ in_sub;
          cnt_d   = '0;
          inv_d   = any_bad;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        // New digit enters at the MSD end; after DIGITS shifts digit 0 is at [3:0].
        sum_d   = W'({slice_digit, sum_q} >> DIGIT_W);
        carry_d = slice_cout;
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          cout_d  = slice_cout ^ sub_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      inv_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      inv_q   <= inv_d;
      cout_q  <= cout_d;
    end
  end

  // Invalid operands still run full length; the result is forced to zero.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = inv_q ? '0 : sum_q;
  assign bus.cout      = cout_q & ~inv_q;
  assign bus.invalid   = inv_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic         pending = 1'b0;
  int           txn_id  = 0;
  int           lat_id  = -1;
  int           acc_cyc = 0;
  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_inv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r = '0;
    longint       x = n;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic on whole operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic c,
                       output logic inv);
    longint m = 1;
    longint r;
    inv = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      m = m * 10;
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) inv = 1'b1;
    end
    if (inv) begin
      s = '0;
      c = 1'b0;
    end else if (!sub) begin
      r = bcd2int(a) + bcd2int(b) + longint'(cin);
      c = (r >= m);
      s = int2bcd(r % m);
    end else begin
      r = bcd2int(a) - bcd2int(b) - longint'(cin);
      c = (r < 0);
      if (r < 0) r = r + m;
      s = int2bcd(r);
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ($urandom_range(0, 15) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            r[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  // Per-cycle result checker.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!pending) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'(pending));
      end else begin
        if (lat_id != txn_id) begin
          check("latency", 32'(cyc - acc_cyc), 32'(DIGITS));
          lat_id <= txn_id;
        end
        check("sum", 32'(bus.sum), 32'(exp_sum));
        check("cout", 32'(bus.cout), 32'(exp_cout));
        check("invalid", 32'(bus.invalid), 32'(exp_inv));
        check("in_ready_busy", 32'(bus.in_ready), 32'(1'b0));
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic ordy, output bit ok);
    int   n = 0;
    logic se;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'(1'b1));
      return;
    end
`ifdef BCD_SUB_EN
    se      = sub;
    bus.sub = sub;
`else
    se      = 1'b0;
`endif
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    model(a, b, cin, se, exp_sum, exp_cout, exp_inv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc_cyc      = cyc;
    txn_id++;
    pending      = 1'b1;
    ok           = 1'b1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int stall, input bit pulse);
    bit ok;
    int n = 0;
    start_op(a, b, cin, sub, (stall == 0), ok);
    if (!ok) return;
    @(negedge clk);
    while (!bus.out_valid && n < 3 * int'(DIGITS)) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 32'(bus.out_valid), 32'(1'b1));
      pending = 1'b0;
      bus.out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      if (pulse && i == 1) begin
        bus.a        = rand_bcd();
        bus.b        = rand_bcd();
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    pending = 1'b0;
  endtask

  logic [W-1:0] ms;
  logic         mc;
  logic         mi;

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef BCD_SUB_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;
    rst           = 1'b1;

    // Pin the model against hand-computed values.
    model(16'h1234, 16'h5678, 1'b0, 1'b0, ms, mc, mi);
    check("model_1234p5678", {15'd0, mc, ms}, {15'd0, 1'b0, 16'h6912});
    model(16'h9999, 16'h0001, 1'b0, 1'b0, ms, mc, mi);
    check("model_9999p0001", {15'd0, mc, ms}, {15'd0, 1'b1, 16'h0000});
    model(16'h9999, 16'h9999, 1'b1, 1'b0, ms, mc, mi);
    check("model_9999p9999c", {15'd0, mc, ms}, {15'd0, 1'b1, 16'h9999});
    model(16'h12A4, 16'h0001, 1'b0, 1'b0, ms, mc, mi);
    check("model_invalid", {14'd0, mi, mc, ms}, {14'd0, 1'b1, 1'b0, 16'h0000});
    model(16'h5000, 16'h1234, 1'b0, 1'b1, ms, mc, mi);
    check("model_5000m1234", {15'd0, mc, ms}, {15'd0, 1'b0, 16'h3766});
    model(16'h1234, 16'h5000, 1'b0, 1'b1, ms, mc, mi);
    check("model_1234m5000", {15'd0, mc, ms}, {15'd0, 1'b1, 16'h6234});
    model(16'h0000, 16'h0000, 1'b1, 1'b1, ms, mc, mi);
    check("model_0m0b", {15'd0, mc, ms}, {15'd0, 1'b1, 16'h9999});

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'(1'b1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_sum", 32'(bus.sum), 32'(0));
    check("rst_cout", 32'(bus.cout), 32'(1'b0));
    check("rst_invalid", 32'(bus.invalid), 32'(1'b0));
    rst = 1'b0;

    do_op(16'h1234, 16'h5678, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h9999, 16'h9999, 1'b1, 1'b0, 0, 1'b0);
    do_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(16'h0500, 16'h0500, 1'b0, 1'b0, 5, 1'b1);
`ifdef BCD_SUB_EN
    do_op(16'h5000, 16'h1234, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h1234, 16'h5000, 1'b0, 1'b1, 0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b0);
`endif

    // Abort an operation while digit 2 is in the slice.
    begin
      bit ok;
      start_op(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b1, ok);
      if (ok) begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        pending = 1'b0;
        check("abort_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("abort_in_ready", 32'(bus.in_ready), 32'(1'b1));
        check("abort_sum", 32'(bus.sum), 32'(0));
        check("abort_cout", 32'(bus.cout), 32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    do_op(16'h0042, 16'h0058, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
